// File: rtl/custom_leds_pwm.sv
// Avalon-MM LED controller: per-channel off/on/PWM/blink with a shared
// prescaler, PWM frame counter and blink phase; duty is double-buffered.
module custom_leds_pwm #(
    parameter int NUM_LEDS = 8,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 196,
    parameter int ADDR_W   = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   avs_address,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    input  logic                avs_read,
    output logic [31:0]         avs_readdata,
    output logic [NUM_LEDS-1:0] leds
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_BLINK = ADDR_W'(1);

    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_ON    = 2'd1;
    localparam logic [1:0] M_PWM   = 2'd2;
    localparam logic [1:0] M_BLINK = 2'd3;

    logic                en;
    logic                inv;
    logic [15:0]         blink_hp;
    logic [15:0]         blink_cnt;
    logic                phase;
    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] shadow_duty [NUM_LEDS];
    logic [PWM_BITS-1:0] active_duty [NUM_LEDS];
    logic [1:0]          mode        [NUM_LEDS];

    logic                tick;
    logic                frame_end;
    logic                blink_on;
    logic                ctrl_wr;
    logic                blink_wr;
    logic [NUM_LEDS-1:0] ch_wr;
    logic [NUM_LEDS-1:0] raw;
    logic [31:0]         rd_next;

    assign tick      = (pre_cnt == PRE_W'(PRESCALE - 1));
    assign frame_end = tick && (pwm_cnt == '1);
    assign blink_on  = (blink_hp == 16'd0) || phase;
    assign ctrl_wr   = avs_write && (avs_address == A_CTRL);
    assign blink_wr  = avs_write && (avs_address == A_BLINK);

    always_comb begin
        ch_wr = '0;
        raw   = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            ch_wr[i] = avs_write && (avs_address == ADDR_W'(i + 2));
            unique case (mode[i])
                M_OFF:   raw[i] = 1'b0;
                M_ON:    raw[i] = 1'b1;
                M_PWM:   raw[i] = (pwm_cnt < active_duty[i]);
                M_BLINK: raw[i] = (pwm_cnt < active_duty[i]) && blink_on;
                default: raw[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            if (tick)
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // A BLINK write restarts the half-period count but keeps the phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_hp == 16'd0) begin
            blink_cnt <= '0;
        end else if (blink_wr) begin
            blink_cnt <= '0;
        end else if (frame_end) begin
            if (blink_cnt == blink_hp - 16'd1) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en       <= 1'b0;
            inv      <= 1'b0;
            blink_hp <= '0;
        end else begin
            if (ctrl_wr) begin
                en  <= avs_writedata[0];
                inv <= avs_writedata[1];
            end
            if (blink_wr)
                blink_hp <= avs_writedata[15:0];
        end
    end

    // Duty written on the frame_end cycle bypasses the shadow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                shadow_duty[i] <= '0;
                active_duty[i] <= '0;
                mode[i]        <= M_OFF;
            end
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (ch_wr[i]) begin
                    shadow_duty[i] <= avs_writedata[PWM_BITS-1:0];
                    mode[i]        <= avs_writedata[17:16];
                end
                if (frame_end)
                    active_duty[i] <= ch_wr[i] ? avs_writedata[PWM_BITS-1:0]
                                               : shadow_duty[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            leds <= '0;
        else
            leds <= en ? (raw ^ {NUM_LEDS{inv}}) : '0;
    end

    always_comb begin
        rd_next = '0;
        if (avs_address == A_CTRL)
            rd_next[1:0] = {inv, en};
        else if (avs_address == A_BLINK)
            rd_next[15:0] = blink_hp;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (avs_address == ADDR_W'(i + 2)) begin
                rd_next[PWM_BITS-1:0] = shadow_duty[i];
                rd_next[17:16]        = mode[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            avs_readdata <= '0;
        else if (avs_read)
            avs_readdata <= rd_next;
    end

endmodule

// File: tb/tb_custom_leds_pwm.sv
// Bench for custom_leds_pwm: frame-aligned LED duty counts and a
// read scoreboard on the Avalon slave.
module tb_custom_leds_pwm;

    localparam int NL    = 8;
    localparam int PRE   = 4;
    localparam int FRAME = 256 * PRE;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic [NL-1:0] leds;

    int n_chk = 0;
    int n_fail = 0;
    int cyc;
    logic rd_v;
    logic [31:0] exp_q[$];

    custom_leds_pwm #(
        .NUM_LEDS(NL), .PWM_BITS(8), .PRESCALE(PRE), .ADDR_W(5)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .avs_address(avs_address), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_read(avs_read),
        .avs_readdata(avs_readdata), .leds(leds)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // cyc equals the number of clocked cycles since reset release
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc  <= 0;
            rd_v <= 1'b0;
        end else begin
            cyc  <= cyc + 1;
            rd_v <= avs_read;
        end
    end

    always @(negedge clk) begin
        if (rd_v) begin
            check("rd_q_size", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0)
                check("readdata", avs_readdata, exp_q.pop_front());
        end
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e);
        avs_address = a; avs_read = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        avs_read = 1'b0;
    endtask

    task automatic rdwr(input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] e);
        avs_address = a; avs_writedata = d;
        avs_write = 1'b1; avs_read = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        avs_write = 1'b0; avs_read = 1'b0;
    endtask

    task automatic wait_state(input int m);
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (cyc % FRAME == m) return;
            @(negedge clk);
        end
        check("wait_state", 32'(cyc % FRAME), 32'(m));
    endtask

    // Samples one whole frame of leds[idx] (one-cycle output latency)
    task automatic measure(input int idx, output int cnt);
        cnt = 0;
        wait_state(1);
        repeat (FRAME) begin
            cnt += int'(leds[idx]);
            @(negedge clk);
        end
    endtask

    int c;
    int c2;
    int blink_exp[6] = '{0, 0, 1020, 1020, 1020, 0};

    initial begin
        #(400000 * 10);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        check("rst_leds", 32'(leds), 32'd0);
        check("rst_rdata", avs_readdata, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        rdwr(5'd0, 32'd1, 32'd0);
        rd(5'd0, 32'd1);
        wr(5'd2, 32'h0002_0040);
        measure(0, c);
        check("pwm64", 32'(c), 32'd256);

        fork
            measure(0, c);
            begin
                wait_state(40);
                wr(5'd2, 32'h0002_00C0);
            end
        join
        check("mid_cur", 32'(c), 32'd256);
        measure(0, c);
        check("mid_next", 32'(c), 32'd768);

        wr(5'd2, 32'h0002_0040);
        wait_state(FRAME - 1);
        wr(5'd2, 32'h0002_00C0);
        measure(0, c);
        check("bypass", 32'(c), 32'd768);

        wr(5'd0, 32'd3);
        wr(5'd2 + 5'd2, 32'h0000_0000);
        repeat (2) @(negedge clk);
        check("inv_off", 32'(leds[2]), 32'd1);
        measure(0, c);
        check("inv_pwm", 32'(c), 32'd256);
        wr(5'd0, 32'd2);
        repeat (2) @(negedge clk);
        check("en0", 32'(leds), 32'd0);
        wr(5'd0, 32'd1);
        wr(5'd5, 32'h0002_0000);
        wr(5'd6, 32'h0001_0000);
        repeat (2) @(negedge clk);
        check("mode_on", 32'(leds[4]), 32'd1);
        measure(3, c);
        check("duty0", 32'(c), 32'd0);

        wr(5'd10, 32'hFFFF_FFFF);
        wr(5'd31, 32'hFFFF_FFFF);
        wr(5'd7, 32'hFFFF_FFFF);
        rd(5'd10, 32'd0);
        rd(5'd31, 32'd0);
        rd(5'd0, 32'd1);
        rd(5'd1, 32'd0);
        rd(5'd2, 32'h0002_00C0);
        rd(5'd6, 32'h0001_0000);
        rd(5'd7, 32'h0003_00FF);

        wait_state(100);
        check("pre_rst_led", 32'(leds[0]), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_leds", 32'(leds), 32'd0);
        check("mid_rst_rdata", avs_readdata, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < NL + 2; a++)
            rd(5'(a), 32'd0);

        wr(5'd0, 32'd1);
        wr(5'd3, 32'h0003_00FF);
        wr(5'd1, 32'd3);
        for (int f = 0; f < 6; f++) begin
            measure(1, c);
            check($sformatf("blink_f%0d", f), 32'(c), 32'(blink_exp[f]));
        end
        wr(5'd1, 32'd0);
        measure(1, c);
        measure(1, c2);
        check("blink0_a", 32'(c), 32'd1020);
        check("blink0_b", 32'(c2), 32'd1020);

        repeat (3) @(negedge clk);
        check("q_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
